// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_pkg
//  Description : Shared constants and helpers for the programmable clock
//                divider: minimum running divisor, high-time computation and
//                channel-index width.
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    // Smallest divisor that keeps a channel running; 0 and 1 stop it.
    localparam int MIN_DIV = 2;

    // Width of a channel index, never narrower than one bit.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Number of high cycles in one period of divisor d (rounded up).
    function automatic logic [31:0] half_up(input logic [31:0] d);
        return (d + 32'd1) >> 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_prog_if.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_prog_if
//  Description : Control/config/output bundle of the programmable divider.
//                master : en, sync, cfg_valid, cfg_ch, cfg_div -> divider
//                         cfg_ready, div_clk, tick            <- divider
//                slave  : the divider side of the same signals.
//  Revision    : 1.0 - initial release
// ============================================================================
interface clk_div_prog_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    import clk_div_pkg::*;

    localparam int CH_W = ch_idx_w(N_CH);

    logic [N_CH-1:0]  en;
    logic             sync;
    logic             cfg_valid;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic [N_CH-1:0]  div_clk;
    logic [N_CH-1:0]  tick;

    modport master (
        output en, sync, cfg_valid, cfg_ch, cfg_div,
        input  cfg_ready, div_clk, tick
    );

    modport slave (
        input  en, sync, cfg_valid, cfg_ch, cfg_div,
        output cfg_ready, div_clk, tick
    );

endinterface
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_chan
//  Description : One divider channel. Holds phase, active divisor, pending
//                divisor and pending flag; drives registered div_clk/tick.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                en            - run enable
//                sync          - restart at phase 0 this edge
//                wr, wr_div    - load pending divisor (only when !pend)
//                pend          - a pending divisor is waiting
//                div_clk, tick - registered divided clock / period strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int RST_DIV = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             en,
    input  wire logic             sync,
    input  wire logic             wr,
    input  wire logic [CNT_W-1:0] wr_div,
    output logic                  pend,
    output logic                  div_clk,
    output logic                  tick
);

    localparam logic [CNT_W-1:0] C_MIN_DIV = CNT_W'(MIN_DIV);
    localparam logic [CNT_W-1:0] C_RST_DIV = CNT_W'(RST_DIV);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    // r_ph is the phase that will be shown in the next output cycle, so the
    // output flops can be loaded from it directly on every edge.
    logic [CNT_W-1:0] r_ph;
    logic [CNT_W-1:0] r_a;
    logic [CNT_W-1:0] r_p;
    logic             r_pend;
    logic             r_div_clk;
    logic             r_tick;

    logic             w_run;
    logic [CNT_W-1:0] w_q;
    logic             w_apply;
    logic [CNT_W-1:0] w_a_eff;
    logic [CNT_W-1:0] w_half;
    logic             w_run_eff;
    logic [CNT_W-1:0] w_ph_nxt;
    logic             w_div_nxt;
    logic             w_tick_nxt;
    logic [CNT_W-1:0] w_p_nxt;
    logic             w_pend_nxt;

    assign w_half = CNT_W'(half_up(32'(w_a_eff)));

    always_comb begin
        w_run   = en && (r_a >= C_MIN_DIV);
        // sync forces the phase shown after this edge back to 0.
        w_q     = sync ? '0 : r_ph;
        // A pending divisor lands either immediately when stopped, or exactly
        // at the start of a new period (natural wrap or sync), never mid-period.
        w_apply = r_pend && (!w_run || (w_q == '0));
        w_a_eff = w_apply ? r_p : r_a;
        // A freshly applied divisor below 2 stops the channel at once.
        w_run_eff = w_run && (w_a_eff >= C_MIN_DIV);

        w_ph_nxt   = '0;
        w_div_nxt  = 1'b0;
        w_tick_nxt = 1'b0;
        if (w_run_eff) begin
            w_ph_nxt   = (w_q == (w_a_eff - C_ONE)) ? '0 : (w_q + C_ONE);
            w_div_nxt  = (w_q < w_half);
            w_tick_nxt = (w_q == '0);
        end

        w_pend_nxt = r_pend;
        w_p_nxt    = r_p;
        if (w_apply) begin
            w_pend_nxt = 1'b0;
        end else if (wr && !r_pend) begin
            w_pend_nxt = 1'b1;
            w_p_nxt    = wr_div;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ph      <= '0;
            r_a       <= C_RST_DIV;
            r_p       <= '0;
            r_pend    <= 1'b0;
            r_div_clk <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_ph      <= w_ph_nxt;
            r_a       <= w_a_eff;
            r_p       <= w_p_nxt;
            r_pend    <= w_pend_nxt;
            r_div_clk <= w_div_nxt;
            r_tick    <= w_tick_nxt;
        end
    end

    assign pend    = r_pend;
    assign div_clk = r_div_clk;
    assign tick    = r_tick;

endmodule
`default_nettype wire

// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_prog
//  Description : Programmable multi-channel clock divider. N_CH independent
//                channels with run-time divisors applied at period
//                boundaries, plus a global sync restart.
//  Ports       : clk, rst - clock, synchronous active-high reset
//                bus      - slave side of clk_div_prog_if (en, sync, config
//                           handshake, div_clk, tick)
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 8,
    parameter int RST_DIV = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
    clk_div_prog_if.slave   bus
);

    localparam int CH_W = ch_idx_w(N_CH);

    logic [N_CH-1:0] w_pend;
    logic [N_CH-1:0] w_wr;
    logic [N_CH-1:0] w_div_clk;
    logic [N_CH-1:0] w_tick;
    logic            w_ch_ok;
    logic            w_ready;

    // Out-of-range channel numbers are always ready; the write is dropped
    // because no channel decodes it.
    assign w_ch_ok = (32'(bus.cfg_ch) < N_CH);
    assign w_ready = w_ch_ok ? !w_pend[bus.cfg_ch] : 1'b1;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
            assign w_wr[gi] = bus.cfg_valid && w_ready &&
                              (bus.cfg_ch == CH_W'(gi));

            clk_div_chan #(
                .CNT_W   (CNT_W),
                .RST_DIV (RST_DIV)
            ) u_chan (
                .clk     (clk),
                .rst     (rst),
                .en      (bus.en[gi]),
                .sync    (bus.sync),
                .wr      (w_wr[gi]),
                .wr_div  (bus.cfg_div),
                .pend    (w_pend[gi]),
                .div_clk (w_div_clk[gi]),
                .tick    (w_tick[gi])
            );
        end
    endgenerate

    assign bus.cfg_ready = w_ready;
    assign bus.div_clk   = w_div_clk;
    assign bus.tick      = w_tick;

endmodule
`default_nettype wire
